// File: rtl/serial_tx_frame_if.sv
// Handshake and line signals of the serial frame transmitter.
// The master side offers words; the slave side is the transmitter.
interface serial_tx_frame_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_req;
  logic             ready;
  logic             serial_out;
  logic             busy;
  logic             bit_tick;

  modport master (
    output data_in,
    output load_req,
    input  ready,
    input  serial_out,
    input  busy,
    input  bit_tick
  );

  modport slave (
    input  data_in,
    input  load_req,
    output ready,
    output serial_out,
    output busy,
    output bit_tick
  );
endinterface

// File: rtl/serial_tx_frame.sv
// Parallel-in, serial-out frame transmitter.
// Sends start bit, WIDTH data bits LSB-first, optional even parity, stop bit.
// Every serial bit lasts BAUD_DIV clocks; the line idles high.
module serial_tx_frame #(
  parameter int WIDTH     = 8,
  parameter int BAUD_DIV  = 4,
  parameter int PARITY_EN = 0
) (
  input  logic               clk,
  input  logic               reset,
  serial_tx_frame_if.slave   bus
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [IW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic             serial_q, serial_d;
  logic             tick_q, tick_d;
  logic             bit_end;

  // Even parity bit: makes the total number of ones (data + parity) even.
  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    serial_d = 1'b1;
    tick_d   = 1'b0;
    bit_end  = (baud_q == BAUD_LAST);

    // Baud counter only runs while a frame is in progress and never
    // passes its terminal value.
    if ((state_q == IDLE) || bit_end) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + BW'(1);
    end

    case (state_q)
      IDLE: begin
        bit_d = '0;
        if (bus.load_req) begin
          state_d = START;
          shift_d = bus.data_in;
          par_d   = even_parity(bus.data_in);
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + IW'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level is decoded from the upcoming state so it changes on the
    // same edge as the state, including the accept edge.
    case (state_d)
      IDLE:    serial_d = 1'b1;
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      PARITY:  serial_d = par_d;
      STOP:    serial_d = 1'b1;
      default: serial_d = 1'b1;
    endcase

    if (state_d != IDLE) begin
      tick_d = (baud_d == BAUD_LAST);
    end else begin
      tick_d = 1'b0;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.ready      = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.serial_out = serial_q;
  assign bus.bit_tick   = tick_q;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Directed bench for serial_tx_frame: one instance without parity and one
// with parity, both WIDTH=8, BAUD_DIV=4. Expected line patterns are
// hand-written constants (bit 0 = start bit, transmitted first).
module tb_serial_tx_frame;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_tx_frame_if #(.WIDTH(8)) if0 ();
  serial_tx_frame_if #(.WIDTH(8)) if1 ();

  serial_tx_frame #(.WIDTH(8), .BAUD_DIV(4), .PARITY_EN(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );
  serial_tx_frame #(.WIDTH(8), .BAUD_DIV(4), .PARITY_EN(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit          sel;
    logic [7:0]  data;
    int          nbits;
    logic [10:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic req, input logic [7:0] d);
    if (sel) begin
      if1.load_req = req;
      if1.data_in  = d;
    end else begin
      if0.load_req = req;
      if0.data_in  = d;
    end
  endtask

  task automatic sample(input bit sel, output logic s, output logic t,
                        output logic r, output logic b);
    if (sel) begin
      s = if1.serial_out; t = if1.bit_tick; r = if1.ready; b = if1.busy;
    end else begin
      s = if0.serial_out; t = if0.bit_tick; r = if0.ready; b = if0.busy;
    end
  endtask

  task automatic check_idle(input bit sel, input string tag);
    logic s, t, r, b;
    sample(sel, s, t, r, b);
    chk({tag, " idle serial"}, s, 1'b1);
    chk({tag, " idle tick"}, t, 1'b0);
    chk({tag, " idle ready"}, r, 1'b1);
    chk({tag, " idle busy"}, b, 1'b0);
  endtask

  task automatic wait_ready(input bit sel);
    logic s, t, r, b;
    int n = 0;
    @(negedge clk);
    sample(sel, s, t, r, b);
    while (!r && n < 200) begin
      @(negedge clk);
      sample(sel, s, t, r, b);
      n++;
    end
    chk("wait_ready", r, 1'b1);
  endtask

  // Called just after accept edge T; checks every clock up to T+F and the
  // idle state after T+F. At cycle inj a busy-time request for 0xFF is raised.
  task automatic check_frame(input bit sel, input string tag,
                             input logic [10:0] exp, input int nbits,
                             input int inj);
    logic s, t, r, b;
    for (int c = 0; c < nbits * 4; c++) begin
      @(negedge clk);
      sample(sel, s, t, r, b);
      chk($sformatf("%s serial c%0d", tag, c), s, exp[c / 4]);
      chk($sformatf("%s tick c%0d", tag, c), t, logic'((c % 4) == 3));
      chk($sformatf("%s ready c%0d", tag, c), r, 1'b0);
      chk($sformatf("%s busy c%0d", tag, c), b, 1'b1);
      if (c == inj) begin
        drive(sel, 1'b1, 8'hFF);
      end
    end
    @(negedge clk);
    check_idle(sel, tag);
  endtask

  task automatic send(input bit sel, input string tag, input logic [7:0] d,
                      input logic [10:0] exp, input int nbits);
    wait_ready(sel);
    drive(sel, 1'b1, d);
    @(posedge clk);
    #1 drive(sel, 1'b0, 8'h00);
    check_frame(sel, tag, exp, nbits, -1);
  endtask

  initial begin
    logic s, t, r, b;

    vecs[0] = '{1'b0, 8'hA5, 10, 11'b0_1_10100101_0, "a5_nopar"};
    vecs[1] = '{1'b1, 8'hA5, 11, 11'b1_0_10100101_0, "a5_par"};
    vecs[2] = '{1'b1, 8'h07, 11, 11'b1_1_00000111_0, "07_par"};
    vecs[3] = '{1'b1, 8'hFF, 11, 11'b1_0_11111111_0, "ff_par"};
    vecs[4] = '{1'b1, 8'h00, 11, 11'b1_0_00000000_0, "00_par"};
    vecs[5] = '{1'b1, 8'h01, 11, 11'b1_1_00000001_0, "01_par"};
    vecs[6] = '{1'b0, 8'h81, 10, 11'b0_1_10000001_0, "81_nopar"};

    // Reset held with load_req high: outputs stay idle, nothing starts.
    reset = 1'b0;
    drive(1'b0, 1'b1, 8'hA5);
    drive(1'b1, 1'b1, 8'hA5);
    repeat (3) begin
      @(negedge clk);
      check_idle(1'b0, "rst0");
      check_idle(1'b1, "rst1");
    end
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    check_idle(1'b0, "post_rst0");
    check_idle(1'b1, "post_rst1");

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].sel, vecs[i].tag, vecs[i].data, vecs[i].exp, vecs[i].nbits);
    end

    // Request during busy is ignored; it is taken once the block is idle.
    wait_ready(1'b0);
    drive(1'b0, 1'b1, 8'h3C);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 8'h3C);
    check_frame(1'b0, "3c_busy", 11'b0_1_00111100_0, 10, 10);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 8'h00);
    check_frame(1'b0, "ff_after_busy", 11'b0_1_11111111_0, 10, -1);

    // Back-to-back with load_req held high; data changes after accept.
    wait_ready(1'b0);
    drive(1'b0, 1'b1, 8'h55);
    @(posedge clk);
    #1 drive(1'b0, 1'b1, 8'hAA);
    check_frame(1'b0, "55_b2b", 11'b0_1_01010101_0, 10, -1);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 8'h00);
    check_frame(1'b0, "aa_b2b", 11'b0_1_10101010_0, 10, -1);

    // Mid-frame asynchronous reset inside a data bit.
    wait_ready(1'b0);
    drive(1'b0, 1'b1, 8'h00);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 8'h00);
    repeat (17) @(posedge clk);
    #1;
    sample(1'b0, s, t, r, b);
    chk("pre_reset serial", s, 1'b0);
    chk("pre_reset ready", r, 1'b0);
    reset = 1'b0;
    #1;
    sample(1'b0, s, t, r, b);
    chk("async_reset serial", s, 1'b1);
    chk("async_reset ready", r, 1'b1);
    chk("async_reset busy", b, 1'b0);
    chk("async_reset tick", t, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    send(1'b0, "81_after_rst", 8'h81, 11'b0_1_10000001_0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
